// File: rtl/uart_rx_sequencer_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   state_e   - receive sequencer states
//   OVERSAMPLE, MID_SAMPLE, LAST_SAMPLE, DATA_BITS - 8N1 / 16x framing defaults
//   maj3()    - 2-of-3 majority vote used by the optional sample filter
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_e;

   localparam int OVERSAMPLE  = 16;
   localparam int MID_SAMPLE  = 7;
   localparam int LAST_SAMPLE = 15;
   localparam int DATA_BITS   = 8;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sequencer_sync2.sv
// uart_sync2: generic two-flop synchroniser for a single asynchronous bit.
//   clk_i    - destination clock
//   nreset_i - synchronous active-low reset
//   d_i      - asynchronous input
//   q_o      - synchronised output (RST_VAL while in reset)
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic nreset_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: 8N1 UART receiver driven by an external 16x oversample tick.
// Detects the start edge, samples each bit at mid-bit, deserialises LSB first
// and checks the stop bit. Good frames update rx_data with a one-cycle rx_valid;
// a low stop bit gives a one-cycle rx_frame_err and the receiver waits for the
// line to return high before looking for another start bit.
//   clk50        - system clock, rising edge
//   nreset       - synchronous active-low reset
//   tick         - oversample strobe, one clk50 wide, not assumed periodic
//   rx           - asynchronous serial line, idle high
//   rx_data      - last correctly framed byte
//   rx_valid     - one-cycle strobe, rx_data updated
//   rx_frame_err - one-cycle strobe, stop bit sampled low
//   busy         - sequencer is not in IDLE
// Build option: define UART_RX_MAJORITY_EN to make every mid-bit decision a
// majority vote over the current and two previous tick samples.
module uart_rx_sequencer
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = uart_pkg::DATA_BITS,
   parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
   input  logic                 clk50,
   input  logic                 nreset,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err,
   output logic                 busy
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam int BC_W = $clog2(DATA_BITS);

   localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

   logic                 rx_s;
   logic                 bit_smp;

   state_e               state_q;
   logic [OS_W-1:0]      os_q;
   logic [BC_W-1:0]      bc_q;
   logic [DATA_BITS-1:0] sh_q;
   logic [DATA_BITS-1:0] rx_data_q;
   logic                 valid_q;
   logic                 err_q;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk_i    (clk50),
      .nreset_i (nreset),
      .d_i      (rx),
      .q_o      (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   // Two previous tick samples; reset to the idle level so a vote right
   // after reset is not biased toward a false low.
   logic [1:0] hist_q;

   always_ff @(posedge clk50) begin
      if (!nreset) begin
         hist_q <= 2'b11;
      end else if (tick) begin
         hist_q <= {hist_q[0], rx_s};
      end
   end

   assign bit_smp = maj3(rx_s, hist_q[0], hist_q[1]);
`else
   assign bit_smp = rx_s;
`endif

   // Everything below advances only on tick; strobes clear every cycle so
   // they stay one clk50 wide regardless of tick spacing.
   always_ff @(posedge clk50) begin
      if (!nreset) begin
         state_q   <= IDLE;
         os_q      <= '0;
         bc_q      <= '0;
         sh_q      <= '0;
         rx_data_q <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (tick) begin
            unique case (state_q)
               IDLE: begin
                  // Start detect stays a single sample even with the vote enabled.
                  if (!rx_s) begin
                     state_q <= START;
                     os_q    <= '0;
                  end
               end
               START: begin
                  os_q <= os_q + 1'b1;
                  if (os_q == OS_MID) begin
                     if (!bit_smp) begin
                        state_q <= DATA;
                        os_q    <= '0;
                        bc_q    <= '0;
                     end else begin
                        state_q <= IDLE;   // glitch, not a start bit
                     end
                  end
               end
               DATA: begin
                  os_q <= os_q + 1'b1;
                  if (os_q == OS_LAST) begin
                     // LSB arrives first, so shift right and enter at the top.
                     sh_q <= {bit_smp, sh_q[DATA_BITS-1:1]};
                     os_q <= '0;
                     if (bc_q == BC_LAST) begin
                        state_q <= STOP;
                     end else begin
                        bc_q <= bc_q + 1'b1;
                     end
                  end
               end
               STOP: begin
                  os_q <= os_q + 1'b1;
                  // Leaving at mid-stop lets a following start edge be seen
                  // with no idle gap between frames.
                  if (os_q == OS_LAST) begin
                     if (bit_smp) begin
                        rx_data_q <= sh_q;
                        valid_q   <= 1'b1;
                        state_q   <= IDLE;
                     end else begin
                        err_q   <= 1'b1;
                        state_q <= BREAK;
                     end
                  end
               end
               BREAK: begin
                  // A held-low line must go high before a new start is accepted.
                  if (rx_s) begin
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign rx_data      = rx_data_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = err_q;
   assign busy         = (state_q != IDLE);

endmodule
